// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants and entry type codes used by the reorder buffer and its clients.
package reorder_buffer_pkg;

  localparam int unsigned ROBSIZE  = 3;
  localparam int unsigned ROB_ID_W = ROBSIZE + 1;

  typedef enum logic [1:0] {
    robtype_r    = 2'b00,
    robtype_b    = 2'b01,
    robtype_s    = 2'b10,
    robtype_exit = 2'b11
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular entry array, CDB writeback, operand bypass,
// single-entry commit with mispredict flush and sticky exit.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                dec_valid,
  input  logic [1:0]          dec_type,
  input  logic [4:0]          dec_rd,
  input  logic [31:0]         dec_imm,
  input  logic [31:0]         dec_pc,
  input  logic                dec_ready_now,
  output logic                rob_full,
  output logic [ROB_ID_W-1:0] next_position,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [31:0]         cdb_value,
  input  logic                cdb_mispredict,
  input  logic [31:0]         cdb_target,
  input  logic [ROB_ID_W-1:0] q1_id,
  output logic                q1_ready,
  output logic [31:0]         q1_value,
  input  logic [ROB_ID_W-1:0] q2_id,
  output logic                q2_ready,
  output logic [31:0]         q2_value,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                commit_store,
  output logic                clear,
  output logic [31:0]         clear_pc,
  output logic                exit
);

  localparam int unsigned CNT_W = $clog2(ROB_DEPTH + 1);

  typedef logic [ROB_ID_W-1:0] id_t;

  logic [ROB_DEPTH-1:0] busy_q, ready_q, mispred_q;
  rob_type_e            type_q   [ROB_DEPTH];
  logic [4:0]           rd_q     [ROB_DEPTH];
  logic [31:0]          value_q  [ROB_DEPTH];
  logic [31:0]          target_q [ROB_DEPTH];

  id_t              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exit_q, exit_d;

  rob_type_e dec_type_e, head_type;
  logic      commit_fire, exit_fire, dispatch_fire, cdb_fire, commit_out;
  logic      unused_pc;

  assign unused_pc  = ^dec_pc;
  assign dec_type_e = rob_type_e'(dec_type);
  assign head_type  = type_q[head_q];

  function automatic id_t wrap_inc(input id_t p);
    return (p == id_t'(ROB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head only commits once its ready bit is registered, giving the 1-cycle writeback-to-commit gap.
  assign commit_fire   = !rst && rdy && !exit_q && (count_q != '0) && ready_q[head_q];
  assign commit_valid  = commit_fire && (head_type == robtype_r);
  assign commit_store  = commit_fire && (head_type == robtype_s);
  assign clear         = commit_fire && (head_type == robtype_b) && mispred_q[head_q];
  assign exit_fire     = commit_fire && (head_type == robtype_exit);
  assign commit_out    = commit_valid || commit_store;

  assign commit_rd     = commit_out ? rd_q[head_q]     : '0;
  assign commit_value  = commit_out ? value_q[head_q]  : '0;
  assign commit_rob_id = commit_out ? head_q           : '0;
  assign clear_pc      = clear      ? target_q[head_q] : '0;

  assign rob_full      = (count_q == CNT_W'(ROB_DEPTH));
  assign next_position = tail_q;
  assign exit          = exit_q;

  assign dispatch_fire = rdy && dec_valid && !rob_full && !clear && !exit_q;
  assign cdb_fire      = rdy && cdb_valid && busy_q[cdb_rob_id];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    exit_d  = exit_q || exit_fire;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire)   head_d = wrap_inc(head_q);
      if (dispatch_fire) tail_d = wrap_inc(tail_q);
      case ({dispatch_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    q1_ready = 1'b0;
    q1_value = '0;
    q2_ready = 1'b0;
    q2_value = '0;
    if (!rst) begin
      if (cdb_valid && (cdb_rob_id == q1_id)) begin
        q1_ready = 1'b1;
        q1_value = cdb_value;
      end else if (ready_q[q1_id]) begin
        q1_ready = 1'b1;
        q1_value = value_q[q1_id];
      end
      if (cdb_valid && (cdb_rob_id == q2_id)) begin
        q2_ready = 1'b1;
        q2_value = cdb_value;
      end else if (ready_q[q2_id]) begin
        q2_ready = 1'b1;
        q2_value = value_q[q2_id];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      exit_q    <= 1'b0;
      busy_q    <= '0;
      ready_q   <= '0;
      mispred_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      exit_q  <= exit_d;
      if (dispatch_fire) begin
        busy_q[tail_q]    <= 1'b1;
        ready_q[tail_q]   <= dec_ready_now || (dec_type_e == robtype_s) || (dec_type_e == robtype_exit);
        mispred_q[tail_q] <= 1'b0;
      end
      if (cdb_fire) begin
        ready_q[cdb_rob_id]   <= 1'b1;
        mispred_q[cdb_rob_id] <= cdb_mispredict;
      end
      if (commit_fire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
      if (clear) begin
        busy_q  <= '0;
        ready_q <= '0;
      end
    end
  end

  // Payload storage needs no reset: every read is qualified by a reset-cleared ready bit.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      type_q[tail_q]   <= dec_type_e;
      rd_q[tail_q]     <= dec_rd;
      value_q[tail_q]  <= dec_ready_now ? dec_imm : '0;
      target_q[tail_q] <= '0;
    end
    if (cdb_fire) begin
      value_q[cdb_rob_id]  <= cdb_value;
      target_q[cdb_rob_id] <= cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// against a queue-based model of in-order commit.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        dec_valid;
  logic [1:0]  dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm, dec_pc;
  logic        dec_ready_now;
  logic        rob_full;
  logic [3:0]  next_position;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_rob_id;
  logic        commit_store, clear;
  logic [31:0] clear_pc;
  logic        exit;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.ROB_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd), .dec_imm(dec_imm),
    .dec_pc(dec_pc), .dec_ready_now(dec_ready_now),
    .rob_full(rob_full), .next_position(next_position),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .q1_id(q1_id), .q1_ready(q1_ready), .q1_value(q1_value),
    .q2_id(q2_id), .q2_ready(q2_ready), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .commit_store(commit_store),
    .clear(clear), .clear_pc(clear_pc), .exit(exit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          ready;
    bit          misp;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];
  int   m_head;
  bit   m_exit;

  task automatic idle_inputs();
    rdy = 1'b1; dec_valid = 1'b0; dec_type = 2'b00; dec_rd = '0; dec_imm = '0; dec_pc = '0;
    dec_ready_now = 1'b0; cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    cdb_mispredict = 1'b0; cdb_target = '0; q1_id = '0; q2_id = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void mquery(input logic [3:0] id, output logic r, output logic [31:0] v);
    r = 1'b0; v = '0;
    if (cdb_valid && cdb_rob_id == id) begin
      r = 1'b1; v = cdb_value;
    end else begin
      foreach (mq[k]) if (mq[k].id == id && mq[k].ready) begin r = 1'b1; v = mq[k].val; end
    end
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", rob_full); end
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL reset_nextpos got=%0d exp=0", next_position); end
    checks++; if (exit !== 1'b0) begin errors++; $display("FAIL reset_exit got=%b exp=0", exit); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got=%b exp=0", commit_valid); end
    dec_valid = 1'b1; dec_type = 2'b00; dec_rd = 5'd3; dec_imm = 32'h55; dec_ready_now = 1'b1;
    next_cyc();
    idle_inputs();
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_commit got=%b exp=1", commit_valid); end
    rst = 1'b1; cdb_valid = 1'b1; cdb_rob_id = 4'd2; cdb_value = 32'h99; q1_id = 4'd2;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_abort_cv got=%b exp=0", commit_valid); end
    checks++; if (commit_rd !== 5'd0) begin errors++; $display("FAIL reset_abort_rd got=%0d exp=0", commit_rd); end
    checks++; if (q1_ready !== 1'b0) begin errors++; $display("FAIL reset_q1_ready got=%b exp=0", q1_ready); end
    checks++; if (next_position !== 4'd1 - 4'd1) begin errors++; $display("FAIL reset_abort_pos got=%0d exp=0", next_position); end
    next_cyc();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_after_cv got=%b exp=0", commit_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    dec_valid = 1'b1; dec_type = 2'b00; dec_rd = 5'd5;
    #1;
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL basic_pos0 got=%0d exp=0", next_position); end
    next_cyc();
    dec_valid = 1'b0; cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'h1234;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_early_cv got=%b exp=0", commit_valid); end
    next_cyc();
    cdb_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL basic_cv got=%b exp=1", commit_valid); end
    checks++; if (commit_rd !== 5'd5) begin errors++; $display("FAIL basic_rd got=%0d exp=5", commit_rd); end
    checks++; if (commit_value !== 32'h1234) begin errors++; $display("FAIL basic_value got=%h exp=1234", commit_value); end
    checks++; if (commit_rob_id !== 4'd0) begin errors++; $display("FAIL basic_id got=%0d exp=0", commit_rob_id); end
    next_cyc();
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", commit_valid); end
    checks++; if (next_position !== 4'd1) begin errors++; $display("FAIL basic_pos1 got=%0d exp=1", next_position); end
  endtask

  task automatic test_full();
    do_reset();
    dec_valid = 1'b1; dec_type = 2'b00; dec_ready_now = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dec_rd = 5'(i);
      #1;
      checks++; if (next_position !== 4'(i)) begin errors++; $display("FAIL full_pos got=%0d exp=%0d", next_position, i); end
      checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0 at=%0d", rob_full, i); end
      next_cyc();
    end
    #1;
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", rob_full); end
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL full_wrap got=%0d exp=0", next_position); end
    next_cyc();
    #1;
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_17_flag got=%b exp=1", rob_full); end
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL full_17_pos got=%0d exp=0", next_position); end
    dec_valid = 1'b0; cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'hBEEF;
    next_cyc();
    cdb_valid = 1'b0; dec_valid = 1'b1;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL full_commit_cv got=%b exp=1", commit_valid); end
    checks++; if (commit_value !== 32'hBEEF) begin errors++; $display("FAIL full_commit_val got=%h exp=beef", commit_value); end
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_commit_flag got=%b exp=1", rob_full); end
    next_cyc();
    dec_valid = 1'b0;
    #1;
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL full_after_commit got=%b exp=0", rob_full); end
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL full_refused_pos got=%0d exp=0", next_position); end
    dec_valid = 1'b1;
    next_cyc();
    dec_valid = 1'b0;
    #1;
    checks++; if (next_position !== 4'd1) begin errors++; $display("FAIL full_refill_pos got=%0d exp=1", next_position); end
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_refill_flag got=%b exp=1", rob_full); end
  endtask

  task automatic test_mispredict();
    do_reset();
    dec_valid = 1'b1; dec_type = 2'b00; dec_rd = 5'd1; dec_imm = 32'hAA; dec_ready_now = 1'b1;
    next_cyc();
    dec_type = 2'b10; dec_ready_now = 1'b0; dec_rd = 5'd0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL mp_c0_cv got=%b exp=1", commit_valid); end
    checks++; if (commit_value !== 32'hAA) begin errors++; $display("FAIL mp_c0_val got=%h exp=aa", commit_value); end
    next_cyc();
    dec_type = 2'b01;
    #1;
    checks++; if (commit_store !== 1'b1) begin errors++; $display("FAIL mp_store got=%b exp=1", commit_store); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL mp_store_cv got=%b exp=0", commit_valid); end
    checks++; if (commit_rob_id !== 4'd1) begin errors++; $display("FAIL mp_store_id got=%0d exp=1", commit_rob_id); end
    next_cyc();
    dec_type = 2'b00;
    cdb_valid = 1'b1; cdb_rob_id = 4'd2; cdb_mispredict = 1'b1; cdb_target = 32'h100;
    #1;
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL mp_early_clear got=%b exp=0", clear); end
    next_cyc();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    #1;
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL mp_clear got=%b exp=1", clear); end
    checks++; if (clear_pc !== 32'h100) begin errors++; $display("FAIL mp_clear_pc got=%h exp=100", clear_pc); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL mp_branch_cv got=%b exp=0", commit_valid); end
    checks++; if (next_position !== 4'd4) begin errors++; $display("FAIL mp_pre_pos got=%0d exp=4", next_position); end
    next_cyc();
    q1_id = 4'd3; dec_rd = 5'd9; dec_imm = 32'h77; dec_ready_now = 1'b1;
    #1;
    checks++; if (next_position !== 4'd0) begin errors++; $display("FAIL mp_post_pos got=%0d exp=0", next_position); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL mp_post_clear got=%b exp=0", clear); end
    checks++; if (q1_ready !== 1'b0) begin errors++; $display("FAIL mp_flushed_q got=%b exp=0", q1_ready); end
    next_cyc();
    dec_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL mp_restart_cv got=%b exp=1", commit_valid); end
    checks++; if (commit_rob_id !== 4'd0) begin errors++; $display("FAIL mp_restart_id got=%0d exp=0", commit_rob_id); end
    checks++; if (commit_value !== 32'h77) begin errors++; $display("FAIL mp_restart_val got=%h exp=77", commit_value); end
  endtask

  task automatic test_query();
    do_reset();
    dec_valid = 1'b1; dec_type = 2'b00;
    repeat (4) next_cyc();
    dec_valid = 1'b0;
    q1_id = 4'd3; q2_id = 4'd2; cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_value = 32'd7;
    #1;
    checks++; if (q1_ready !== 1'b1) begin errors++; $display("FAIL q_bypass_ready got=%b exp=1", q1_ready); end
    checks++; if (q1_value !== 32'd7) begin errors++; $display("FAIL q_bypass_value got=%0d exp=7", q1_value); end
    checks++; if (q2_ready !== 1'b0) begin errors++; $display("FAIL q_not_ready got=%b exp=0", q2_ready); end
    next_cyc();
    cdb_valid = 1'b0; q2_id = 4'd3;
    #1;
    checks++; if (q2_ready !== 1'b1) begin errors++; $display("FAIL q_stored_ready got=%b exp=1", q2_ready); end
    checks++; if (q2_value !== 32'd7) begin errors++; $display("FAIL q_stored_value got=%0d exp=7", q2_value); end
    rdy = 1'b0; cdb_valid = 1'b1; cdb_rob_id = 4'd2; cdb_value = 32'd9;
    next_cyc();
    cdb_valid = 1'b0; q2_id = 4'd2;
    #1;
    checks++; if (q2_ready !== 1'b0) begin errors++; $display("FAIL q_frozen got=%b exp=0", q2_ready); end
    rdy = 1'b1;
  endtask

  task automatic test_exit();
    do_reset();
    dec_valid = 1'b1; dec_type = 2'b11;
    next_cyc();
    dec_type = 2'b00; dec_ready_now = 1'b1; dec_rd = 5'd7; dec_imm = 32'd1;
    #1;
    checks++; if (exit !== 1'b0) begin errors++; $display("FAIL exit_early got=%b exp=0", exit); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL exit_commit_cv got=%b exp=0", commit_valid); end
    next_cyc();
    for (int i = 0; i < 6; i++) begin
      dec_valid = 1'($urandom_range(0, 1)); dec_type = 2'($urandom_range(0, 3));
      cdb_valid = 1'b1; cdb_rob_id = 4'd1; cdb_value = $urandom;
      #1;
      checks++; if (exit !== 1'b1) begin errors++; $display("FAIL exit_held got=%b exp=1 at=%0d", exit, i); end
      checks++; if (commit_valid !== 1'b0 || commit_store !== 1'b0) begin
        errors++; $display("FAIL exit_no_commit got=%b%b exp=00 at=%0d", commit_valid, commit_store, i); end
      checks++; if (next_position !== 4'd2) begin errors++; $display("FAIL exit_no_dispatch got=%0d exp=2", next_position); end
      next_cyc();
    end
  endtask

  task automatic test_random();
    int          exit_cnt;
    int          tail, sz, pick;
    int          cand[$];
    logic        e_full, e_fire, e_cv, e_cs, e_clr, acc, e_r1, e_r2;
    logic [31:0] e_v1, e_v2;
    ent_t        ne, hd;
    do_reset();
    mq.delete(); m_head = 0; m_exit = 0; exit_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((m_exit && exit_cnt > 8) || $urandom_range(0, 399) == 0) begin
        do_reset();
        mq.delete(); m_head = 0; m_exit = 0; exit_cnt = 0;
        continue;
      end
      rdy           = ($urandom_range(0, 7) != 0);
      dec_valid     = ($urandom_range(0, 9) < 6);
      pick          = $urandom_range(0, 99);
      dec_type      = (pick < 50) ? 2'b00 : (pick < 75) ? 2'b01 : (pick < 97) ? 2'b10 : 2'b11;
      dec_rd        = 5'($urandom);
      dec_imm       = $urandom;
      dec_pc        = $urandom;
      dec_ready_now = ($urandom_range(0, 3) == 0);
      cand.delete();
      foreach (mq[k]) if (!mq[k].ready) cand.push_back(int'(mq[k].id));
      cdb_valid      = ($urandom_range(0, 9) < 6);
      cdb_rob_id     = (cand.size() > 0 && $urandom_range(0, 3) != 0) ?
                       4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom);
      cdb_value      = $urandom;
      cdb_mispredict = ($urandom_range(0, 5) == 0);
      cdb_target     = $urandom;
      q1_id          = 4'($urandom);
      q2_id          = (cand.size() > 0) ? 4'(cand[0]) : 4'($urandom);
      #1;
      sz     = mq.size();
      tail   = (m_head + sz) % 16;
      e_full = (sz == 16);
      e_fire = rdy && !m_exit && sz > 0 && mq[0].ready;
      e_cv   = e_fire && mq[0].typ == 2'b00;
      e_cs   = e_fire && mq[0].typ == 2'b10;
      e_clr  = e_fire && mq[0].typ == 2'b01 && mq[0].misp;
      mquery(q1_id, e_r1, e_v1);
      mquery(q2_id, e_r2, e_v2);
      checks++; if (rob_full !== e_full) begin errors++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, rob_full, e_full); end
      checks++; if (next_position !== 4'(tail)) begin errors++; $display("FAIL rand_pos cyc=%0d got=%0d exp=%0d", cyc, next_position, tail); end
      checks++; if (commit_valid !== e_cv) begin errors++; $display("FAIL rand_cv cyc=%0d got=%b exp=%b", cyc, commit_valid, e_cv); end
      checks++; if (commit_store !== e_cs) begin errors++; $display("FAIL rand_cs cyc=%0d got=%b exp=%b", cyc, commit_store, e_cs); end
      checks++; if (clear !== e_clr) begin errors++; $display("FAIL rand_clear cyc=%0d got=%b exp=%b", cyc, clear, e_clr); end
      checks++; if (exit !== m_exit) begin errors++; $display("FAIL rand_exit cyc=%0d got=%b exp=%b", cyc, exit, m_exit); end
      checks++; if (q1_ready !== e_r1 || (e_r1 && q1_value !== e_v1)) begin
        errors++; $display("FAIL rand_q1 cyc=%0d got=%b/%h exp=%b/%h", cyc, q1_ready, q1_value, e_r1, e_v1); end
      checks++; if (q2_ready !== e_r2 || (e_r2 && q2_value !== e_v2)) begin
        errors++; $display("FAIL rand_q2 cyc=%0d got=%b/%h exp=%b/%h", cyc, q2_ready, q2_value, e_r2, e_v2); end
      if (e_cv) begin
        checks++; if (commit_rd !== mq[0].rd || commit_value !== mq[0].val || commit_rob_id !== mq[0].id) begin
          errors++; $display("FAIL rand_commit_data cyc=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", cyc,
                              commit_rd, commit_value, commit_rob_id, mq[0].rd, mq[0].val, mq[0].id); end
      end
      if (e_cs) begin
        checks++; if (commit_rob_id !== mq[0].id) begin
          errors++; $display("FAIL rand_store_id cyc=%0d got=%0d exp=%0d", cyc, commit_rob_id, mq[0].id); end
      end
      if (e_clr) begin
        checks++; if (clear_pc !== mq[0].tgt) begin
          errors++; $display("FAIL rand_clear_pc cyc=%0d got=%h exp=%h", cyc, clear_pc, mq[0].tgt); end
      end
      acc = rdy && dec_valid && !e_full && !e_clr && !m_exit;
      if (rdy) begin
        if (cdb_valid) begin
          foreach (mq[k]) if (mq[k].id == cdb_rob_id) begin
            mq[k].ready = 1; mq[k].val = cdb_value; mq[k].misp = cdb_mispredict; mq[k].tgt = cdb_target;
          end
        end
        if (e_fire) begin
          hd = mq.pop_front();
          m_head = (m_head + 1) % 16;
          if (e_clr) begin mq.delete(); m_head = 0; end
          if (hd.typ == 2'b11) m_exit = 1;
        end
        if (acc) begin
          ne.id = 4'(tail); ne.typ = dec_type; ne.rd = dec_rd;
          ne.val = dec_ready_now ? dec_imm : 32'd0;
          ne.ready = dec_ready_now || dec_type == 2'b10 || dec_type == 2'b11;
          ne.misp = 0; ne.tgt = '0;
          mq.push_back(ne);
        end
      end
      if (m_exit) exit_cnt++;
      next_cyc();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_query();
    test_exit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
